// File: rtl/divby4_stream_tx.sv
// MSB-first serialiser feeding the divby4 detector, with a golden running-value-mod-4 flag.
// Continuous stream since reset: the flag history survives idle gaps and word boundaries.
//
// state | meaning
// IDLE  | dout_valid = 0, no word in flight, dout held at 0
// SHIFT | dout_valid = 1, cnt bits of the current word still to follow dout
module divby4_stream_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             exp_divby4
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [1:0]       hist;
  logic             accept;

  assign last       = dout_valid && (cnt == '0);
  assign word_ready = !dout_valid || last;
  assign accept     = word_valid && word_ready;
  // Value mod 4 of an MSB-first number is its two least significant bits.
  assign exp_divby4 = (hist == 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr         <= '0;
      cnt        <= '0;
      hist       <= 2'b00;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      if (dout_valid) hist <= {hist[0], dout};
      if (accept) begin
        dout       <= word_in[WIDTH-1];
        sr         <= word_in << 1;
        cnt        <= CW'(WIDTH - 1);
        dout_valid <= 1'b1;
      end else if (dout_valid) begin
        if (cnt != '0) begin
          dout <= sr[WIDTH-1];
          sr   <= sr << 1;
          cnt  <= cnt - CW'(1);
        end else begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
        end
      end
    end
  end

endmodule
